unidade_mul_div: RTL and testbench

// - Multi-cycle integer multiply/divide unit beside the ALU in the execute stage.
// - Consumes the two register-file read operands (RS, RT).
// - Produces a 32-bit result plus register-write strobe and destination, which drive the register file write port.
// - Keeps HI/LO internally (MIPS-style); LO goes to the register file, HI is exposed for mfhi-style moves.

---
 rtl/unidade_mul_div_pkg.sv | 27 ++
 rtl/unidade_mul_div_if.sv | 27 ++
 rtl/unidade_mul_div_passo.sv | 40 ++++
 rtl/unidade_mul_div.sv | 165 ++++++++++++++++
 tb/tb_unidade_mul_div.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/unidade_mul_div_pkg.sv
// Shared types and constants for the multiply/divide unit.
package unidade_mul_div_pkg;

  localparam int unsigned LARGURA = 32;
  localparam int unsigned CONT_W  = $clog2(LARGURA);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } operacao_e;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    CALC   = 2'b01,
    AJUSTE = 2'b10,
    FIM    = 2'b11
  } estado_e;

  // Absolute value for signed operations; unsigned operands pass through.
  function automatic logic [LARGURA-1:0] magnitude(input logic [LARGURA-1:0] v,
                                                   input logic com_sinal);
    return (com_sinal && v[LARGURA-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/unidade_mul_div_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
interface unidade_mul_div_if;
  import unidade_mul_div_pkg::*;

  logic               inicio;
  logic [1:0]         operacao;
  logic [LARGURA-1:0] opA;
  logic [LARGURA-1:0] opB;
  logic [4:0]         destinoIn;
  logic               ocupado;
  logic               pronto;
  logic               escritaReg;
  logic [4:0]         destinoOut;
  logic [LARGURA-1:0] resultado;
  logic [LARGURA-1:0] hi;
  logic               divZero;

  modport slave (
    input  inicio, operacao, opA, opB, destinoIn,
    output ocupado, pronto, escritaReg, destinoOut, resultado, hi, divZero
  );

  modport master (
    output inicio, operacao, opA, opB, destinoIn,
    input  ocupado, pronto, escritaReg, destinoOut, resultado, hi, divZero
  );
endinterface

// File: rtl/unidade_mul_div_passo.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Accumulator layout: upper half = partial product / remainder,
// lower half = remaining multiplier bits / dividend bits becoming quotient bits.
module passo_mul_div
  import unidade_mul_div_pkg::*;
(
  input  logic [2*LARGURA-1:0] acumulador_i,
  input  logic [LARGURA-1:0]   operando_i,
  input  logic                 modo_div_i,
  output logic [2*LARGURA-1:0] acumulador_o
);

  logic [LARGURA:0] soma;
  logic [LARGURA:0] resto_desloc;
  logic [LARGURA:0] tentativa;
  logic             bit_quoc;

  // Single combinational step; the carry of the add is kept by shifting right.
  always_comb begin
    soma         = '0;
    resto_desloc = '0;
    tentativa    = '0;
    bit_quoc     = 1'b0;
    acumulador_o = acumulador_i;
    if (modo_div_i) begin
      resto_desloc = acumulador_i[2*LARGURA-1:LARGURA-1];
      tentativa    = resto_desloc - {1'b0, operando_i};
      bit_quoc     = (resto_desloc >= {1'b0, operando_i});
      acumulador_o = {(bit_quoc ? tentativa[LARGURA-1:0] : resto_desloc[LARGURA-1:0]),
                      acumulador_i[LARGURA-2:0], bit_quoc};
    end else begin
      soma = {1'b0, acumulador_i[2*LARGURA-1:LARGURA]};
      if (acumulador_i[0]) begin
        soma = soma + {1'b0, operando_i};
      end
      acumulador_o = {soma, acumulador_i[LARGURA-1:1]};
    end
  end

endmodule

// File: rtl/unidade_mul_div.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with internal HI/LO.
// Works on magnitudes for 32 cycles, then fixes signs and publishes the result
// for exactly one FIM cycle, during which the register file writes LO.
//
// state  | meaning
// OCIOSO | idle, accepts inicio
// CALC   | one radix-2 iteration per cycle, LARGURA cycles
// AJUSTE | sign fixup, load resultado/hi/destinoOut/divZero
// FIM    | pronto pulse, outputs stable
module unidade_mul_div
  import unidade_mul_div_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  unidade_mul_div_if.slave bus
);

  estado_e              estado_q, estado_d;
  operacao_e            op_q, op_d;
  logic [CONT_W-1:0]    cont_q, cont_d;
  logic [4:0]           dest_q, dest_d;
  logic [4:0]           dest_out_q, dest_out_d;
  logic [LARGURA-1:0]   opa_q, opa_d;
  logic [LARGURA-1:0]   opb_q, opb_d;
  logic                 sinal_a_q, sinal_a_d;
  logic                 sinal_b_q, sinal_b_d;
  logic [2*LARGURA-1:0] acc_q, acc_d;
  logic [LARGURA-1:0]   resultado_q, resultado_d;
  logic [LARGURA-1:0]   hi_q, hi_d;
  logic                 divzero_q, divzero_d;

  logic                 modo_div;
  logic                 com_sinal_in;
  logic [LARGURA-1:0]   mag_a, mag_b;
  logic [2*LARGURA-1:0] acc_passo;
  logic [2*LARGURA-1:0] produto_aj;
  logic [LARGURA-1:0]   quoc_aj, resto_aj;
  logic                 sinais_dif;
  logic                 pronto;

  assign modo_div     = op_q[1];
  assign com_sinal_in = ~bus.operacao[0];
  assign mag_a        = magnitude(bus.opA, com_sinal_in);
  assign mag_b        = magnitude(bus.opB, com_sinal_in);
  assign sinais_dif   = sinal_a_q ^ sinal_b_q;

  passo_mul_div u_passo (
    .acumulador_i (acc_q),
    .operando_i   (modo_div ? opb_q : opa_q),
    .modo_div_i   (modo_div),
    .acumulador_o (acc_passo)
  );

  // Sign fixup; restoring division by zero already yields all-ones quotient
  // and |opA| remainder, the quotient is forced so its sign is never flipped.
  always_comb begin
    produto_aj = sinais_dif ? (~acc_q + 1'b1) : acc_q;
    quoc_aj    = sinais_dif ? (~acc_q[LARGURA-1:0] + 1'b1) : acc_q[LARGURA-1:0];
    resto_aj   = sinal_a_q ? (~acc_q[2*LARGURA-1:LARGURA] + 1'b1)
                           : acc_q[2*LARGURA-1:LARGURA];
    if (opb_q == '0) begin
      quoc_aj = '1;
    end
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    estado_d    = estado_q;
    op_d        = op_q;
    cont_d      = cont_q;
    dest_d      = dest_q;
    dest_out_d  = dest_out_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    sinal_a_d   = sinal_a_q;
    sinal_b_d   = sinal_b_q;
    acc_d       = acc_q;
    resultado_d = resultado_q;
    hi_d        = hi_q;
    divzero_d   = divzero_q;
    pronto      = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (bus.inicio) begin
          op_d      = operacao_e'(bus.operacao);
          dest_d    = bus.destinoIn;
          opa_d     = mag_a;
          opb_d     = mag_b;
          sinal_a_d = com_sinal_in & bus.opA[LARGURA-1];
          sinal_b_d = com_sinal_in & bus.opB[LARGURA-1];
          cont_d    = '0;
          acc_d     = {{LARGURA{1'b0}}, (bus.operacao[1] ? mag_a : mag_b)};
          estado_d  = CALC;
        end
      end
      CALC: begin
        acc_d  = acc_passo;
        cont_d = cont_q + 1'b1;
        if (cont_q == CONT_W'(LARGURA - 1)) begin
          estado_d = AJUSTE;
        end
      end
      AJUSTE: begin
        dest_out_d = dest_q;
        if (modo_div) begin
          resultado_d = quoc_aj;
          hi_d        = resto_aj;
          divzero_d   = (opb_q == '0);
        end else begin
          resultado_d = produto_aj[LARGURA-1:0];
          hi_d        = produto_aj[2*LARGURA-1:LARGURA];
          divzero_d   = 1'b0;
        end
        estado_d = FIM;
      end
      FIM: begin
        pronto   = 1'b1;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      estado_q    <= OCIOSO;
      op_q        <= OP_MULT;
      cont_q      <= '0;
      dest_q      <= '0;
      dest_out_q  <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      sinal_a_q   <= 1'b0;
      sinal_b_q   <= 1'b0;
      acc_q       <= '0;
      resultado_q <= '0;
      hi_q        <= '0;
      divzero_q   <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      op_q        <= op_d;
      cont_q      <= cont_d;
      dest_q      <= dest_d;
      dest_out_q  <= dest_out_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      sinal_a_q   <= sinal_a_d;
      sinal_b_q   <= sinal_b_d;
      acc_q       <= acc_d;
      resultado_q <= resultado_d;
      hi_q        <= hi_d;
      divzero_q   <= divzero_d;
    end
  end

  assign bus.ocupado    = (estado_q != OCIOSO);
  assign bus.pronto     = pronto;
  assign bus.escritaReg = pronto && (dest_out_q != 5'd0);
  assign bus.destinoOut = dest_out_q;
  assign bus.resultado  = resultado_q;
  assign bus.hi         = hi_q;
  assign bus.divZero    = divzero_q;

endmodule

// File: tb/tb_unidade_mul_div.sv
// Bench for unidade_mul_div: expected results are queued when an operation is
// issued and compared when pronto appears.
module tb_unidade_mul_div;

  localparam int LAT_EDGES = 33;  // edges after the sampling edge until pronto

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    logic [4:0]  dest;
    logic        wr;
  } esperado_t;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  int total = 0;
  int bad = 0;
  esperado_t sb[$];

  unidade_mul_div_if bus();

  unidade_mul_div dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic esperado_t modelo(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [4:0] d);
    esperado_t e;
    longint sa, sb_, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    e.dz = 1'b0;
    e.dest = d;
    e.wr = (d != 5'd0);
    case (op)
      2'b00: begin p = sa * sb_; e.lo = p[31:0]; e.hi = p[63:32]; end
      2'b01: begin p = ua * ub; e.lo = p[31:0]; e.hi = p[63:32]; end
      2'b10: begin
        if (b == 32'd0) begin e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1; end
        else begin q = sa / sb_; r = sa % sb_; e.lo = q[31:0]; e.hi = r[31:0]; end
      end
      default: begin
        if (b == 32'd0) begin e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
    endcase
    return e;
  endfunction

  // Issue one operation, optionally pulse a foreign inicio at T+5, and check
  // latency, result fields and the single-cycle pronto.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input bit pulso_extra);
    int n;
    bit got;
    esperado_t e;
    n = 0;
    while (bus.ocupado === 1'b1 && n < 100) begin
      @(posedge clk_i); #1; n++;
    end
    total++;
    if (n >= 100) begin bad++; $display("FAIL idle_wait ocupado=%b still busy", bus.ocupado); end
    @(negedge clk_i);
    bus.operacao = op; bus.opA = a; bus.opB = b; bus.destinoIn = d; bus.inicio = 1'b1;
    sb.push_back(modelo(op, a, b, d));
    @(posedge clk_i); #1;
    bus.inicio = 1'b0;
    bus.opA = $urandom; bus.opB = $urandom; bus.destinoIn = 5'($urandom);
    n = 0;
    got = 0;
    while (!got && n < 60) begin
      @(posedge clk_i); #1; n++;
      if (pulso_extra && n == 4) begin
        bus.inicio = 1'b1; bus.operacao = ~op; bus.opA = 32'h1234_5678; bus.opB = 32'h9;
        bus.destinoIn = 5'd17;
      end else if (n == 5) begin
        bus.inicio = 1'b0;
      end
      if (bus.pronto === 1'b1) got = 1;
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL pronto_timeout op=%0d waited=%0d cycles", op, n);
    end else begin
      if (n !== LAT_EDGES) begin
        bad++; $display("FAIL latency op=%0d got=%0d want=%0d", op, n, LAT_EDGES);
      end
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL scoreboard_empty pronto with nothing pending");
      end else begin
        e = sb.pop_front();
        total++;
        if (bus.resultado !== e.lo) begin
          bad++; $display("FAIL resultado op=%0d got=%h want=%h", op, bus.resultado, e.lo);
        end
        total++;
        if (bus.hi !== e.hi) begin
          bad++; $display("FAIL hi op=%0d got=%h want=%h", op, bus.hi, e.hi);
        end
        total++;
        if (bus.divZero !== e.dz) begin
          bad++; $display("FAIL divZero op=%0d got=%b want=%b", op, bus.divZero, e.dz);
        end
        total++;
        if (bus.destinoOut !== e.dest) begin
          bad++; $display("FAIL destinoOut got=%0d want=%0d", bus.destinoOut, e.dest);
        end
        total++;
        if (bus.escritaReg !== e.wr) begin
          bad++; $display("FAIL escritaReg got=%b want=%b", bus.escritaReg, e.wr);
        end
      end
      @(posedge clk_i); #1;
      total++;
      if (bus.pronto !== 1'b0 || bus.ocupado !== 1'b0) begin
        bad++; $display("FAIL pronto_end pronto=%b ocupado=%b want 0 0", bus.pronto, bus.ocupado);
      end
    end
  endtask

  task automatic test_reset();
    bus.inicio = 1'b0; bus.operacao = 2'b00; bus.opA = '0; bus.opB = '0; bus.destinoIn = '0;
    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    total++;
    if ({bus.ocupado, bus.pronto, bus.escritaReg, bus.divZero} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000",
                      {bus.ocupado, bus.pronto, bus.escritaReg, bus.divZero});
    end
    total++;
    if (bus.resultado !== 32'd0 || bus.hi !== 32'd0 || bus.destinoOut !== 5'd0) begin
      bad++; $display("FAIL reset_data resultado=%h hi=%h dest=%0d want 0", bus.resultado,
                      bus.hi, bus.destinoOut);
    end
  endtask

  task automatic test_multu_max();
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b0);
  endtask

  task automatic test_signed();
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 5'd3, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF6, 32'd0, 5'd7, 1'b0);
  endtask

  task automatic test_div_zero();
    do_op(2'b11, 32'd10, 32'd0, 5'd8, 1'b0);
    total++;
    if (bus.divZero !== 1'b1) begin
      bad++; $display("FAIL divZero_hold got=%b want=1", bus.divZero);
    end
    do_op(2'b11, 32'd10, 32'd3, 5'd9, 1'b0);
  endtask

  task automatic test_ignored_inicio();
    int pulsos;
    do_op(2'b01, 32'd1000, 32'd3000, 5'd10, 1'b1);
    pulsos = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (bus.pronto === 1'b1 || bus.ocupado === 1'b1) pulsos++;
    end
    total++;
    if (pulsos !== 0) begin
      bad++; $display("FAIL ignored_inicio extra_activity=%0d want=0", pulsos);
    end
  endtask

  task automatic test_reset_abort();
    int pulsos;
    @(negedge clk_i);
    bus.operacao = 2'b01; bus.opA = 32'd77; bus.opB = 32'd88; bus.destinoIn = 5'd12;
    bus.inicio = 1'b1;
    @(posedge clk_i); #1;
    bus.inicio = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    total++;
    if (bus.ocupado !== 1'b0) begin
      bad++; $display("FAIL abort_ocupado got=%b want=0", bus.ocupado);
    end
    pulsos = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (bus.pronto === 1'b1 || bus.escritaReg === 1'b1) pulsos++;
    end
    total++;
    if (pulsos !== 0) begin
      bad++; $display("FAIL abort_pronto pulses=%0d want=0", pulsos);
    end
    do_op(2'b00, 32'd12, 32'hFFFF_FFFE, 5'd13, 1'b0);
  endtask

  task automatic test_dest_zero();
    do_op(2'b00, 32'd2, 32'd3, 5'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] b;
    for (int i = 0; i < 8; i++) begin
      b = (i == 5) ? 32'd0 : $urandom;
      if (i == 2) b = b >> 20;
      do_op(2'($urandom_range(0, 3)), $urandom, b, 5'($urandom), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_div_zero();
    test_ignored_inicio();
    test_reset_abort();
    test_dest_zero();
    test_back_to_back();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
